// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one regfile access slot between requesters A and B.
// Each op takes three cycles (IDLE -> ISSUE -> RESP). Requests arriving while an op is in flight wait until IDLE.
module regfile_arbiter #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int PROT_LO = 14
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_sel1,
    input  logic [ADDR_W-1:0] a_sel2,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata1,
    output logic [DATA_W-1:0] a_rdata2,
    output logic              a_err,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_sel1,
    input  logic [ADDR_W-1:0] b_sel2,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata1,
    output logic [DATA_W-1:0] b_rdata2,
    output logic              b_err,

    output logic [ADDR_W-1:0] rf_sel1,
    output logic [ADDR_W-1:0] rf_sel2,
    output logic [DATA_W-1:0] rf_in,
    output logic              rf_write_en,
    input  logic [DATA_W-1:0] rf_out1,
    input  logic [DATA_W-1:0] rf_out2
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [ADDR_W-1:0] PROT_IDX = ADDR_W'(PROT_LO);

    state_t            state, state_nxt;
    logic              owner_b;
    logic              last_b;
    logic              op_rej;
    logic              any_req;
    logic              pick_b;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_s1;
    logic [ADDR_W-1:0] sel_s2;
    logic [DATA_W-1:0] sel_wd;
    logic              wr_ok;

    assign any_req = a_req | b_req;
    // On a tie, B wins only when A was granted last.
    assign pick_b  = b_req & (~a_req | ~last_b);

    assign sel_we = pick_b ? b_we    : a_we;
    assign sel_s1 = pick_b ? b_sel1  : a_sel1;
    assign sel_s2 = pick_b ? b_sel2  : a_sel2;
    assign sel_wd = pick_b ? b_wdata : a_wdata;
    assign wr_ok  = (sel_s1 != '0) && (sel_s1 < PROT_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_b     <= 1'b0;
            last_b      <= 1'b1;
            op_rej      <= 1'b0;
            rf_sel1     <= '0;
            rf_sel2     <= '0;
            rf_in       <= '0;
            rf_write_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_b     <= pick_b;
                        last_b      <= pick_b;
                        rf_sel1     <= sel_s1;
                        rf_sel2     <= sel_s2;
                        rf_in       <= sel_wd;
                        rf_write_en <= sel_we & wr_ok;
                        op_rej      <= sel_we & ~wr_ok;
                    end else begin
                        rf_write_en <= 1'b0;
                    end
                end
                default: rf_write_en <= 1'b0;
            endcase
        end
    end

    assign a_gnt    = (state == ISSUE) & ~owner_b;
    assign b_gnt    = (state == ISSUE) &  owner_b;
    assign a_rvalid = (state == RESP)  & ~owner_b;
    assign b_rvalid = (state == RESP)  &  owner_b;

    // Regfile outputs are registered, so in RESP they hold the reads taken at the end of ISSUE.
    assign a_rdata1 = a_rvalid ? rf_out1 : '0;
    assign a_rdata2 = a_rvalid ? rf_out2 : '0;
    assign b_rdata1 = b_rvalid ? rf_out1 : '0;
    assign b_rdata2 = b_rvalid ? rf_out2 : '0;
    assign a_err    = a_rvalid & op_rej;
    assign b_err    = b_rvalid & op_rej;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized bench for regfile_arbiter: a behavioural regfile plant plus a transaction-level model
// that predicts grants, responses and writes from the arbitration rules.
module tb_regfile_arbiter;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    always #5 clk = ~clk;

    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_sel1, a_sel2, b_sel1, b_sel2;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
    logic [DW-1:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
    logic [AW-1:0] rf_sel1, rf_sel2;
    logic [DW-1:0] rf_in, rf_out1, rf_out2;
    logic          rf_write_en;

    regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PROT_LO(14)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_sel1(a_sel1), .a_sel2(a_sel2), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata1(a_rdata1), .a_rdata2(a_rdata2), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_sel1(b_sel1), .b_sel2(b_sel2), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata1(b_rdata1), .b_rdata2(b_rdata2), .b_err(b_err),
        .rf_sel1(rf_sel1), .rf_sel2(rf_sel2), .rf_in(rf_in), .rf_write_en(rf_write_en),
        .rf_out1(rf_out1), .rf_out2(rf_out2)
    );

    // Regfile plant: registered reads, write on the same edge (read returns the old value).
    logic [DW-1:0] mem [16];
    logic          pl;

    function automatic logic [DW-1:0] init_val(int i);
        case (i)
            2:       return 16'h0001;
            3:       return 16'h1234;
            5:       return 16'hBEEF;
            7:       return 16'h0707;
            default: return 16'(i * 16'h0101) ^ 16'h3C00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (pl) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
            rf_out1 <= '0;
            rf_out2 <= '0;
        end else begin
            rf_out1 <= mem[rf_sel1];
            rf_out2 <= mem[rf_sel2];
            if (rf_write_en) mem[rf_sel1] <= rf_in;
        end
    end

    logic [1:0]    gnt_v, rv_v, err_v;
    logic [DW-1:0] rd1_v [2];
    logic [DW-1:0] rd2_v [2];
    assign gnt_v = {b_gnt, a_gnt};
    assign rv_v  = {b_rvalid, a_rvalid};
    assign err_v = {b_err, a_err};
    assign rd1_v[0] = a_rdata1;
    assign rd1_v[1] = b_rdata1;
    assign rd2_v[0] = a_rdata2;
    assign rd2_v[1] = b_rdata2;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic          we;
        logic [AW-1:0] s1;
        logic [AW-1:0] s2;
        logic [DW-1:0] wd;
    } op_t;

    op_t qa [$];
    op_t qb [$];
    op_t cur [2];
    bit  cur_vld [2];
    bit  rand_en;

    // Transaction-level reference: an op granted at edge t owns the slot until edge t+3.
    logic [DW-1:0] ref_regs [16];
    int            t, free_at, wen_t;
    int            gnt_t [2];
    int            cnt_gnt [2];
    bit            last_b;
    logic [DW-1:0] exp_r1 [2];
    logic [DW-1:0] exp_r2 [2];
    bit            exp_err [2];

    function automatic op_t mk(bit we, int s1, int s2, int wd);
        op_t o;
        o.we = we;
        o.s1 = AW'(s1);
        o.s2 = AW'(s2);
        o.wd = DW'(wd);
        return o;
    endfunction

    task automatic drive();
        a_req = cur_vld[0]; a_we = cur[0].we; a_sel1 = cur[0].s1; a_sel2 = cur[0].s2; a_wdata = cur[0].wd;
        b_req = cur_vld[1]; b_we = cur[1].we; b_sel1 = cur[1].s1; b_sel2 = cur[1].s2; b_wdata = cur[1].wd;
    endtask

    task automatic refill();
        if (!cur_vld[0]) begin
            if (qa.size() > 0) begin
                cur[0] = qa.pop_front(); cur_vld[0] = 1'b1;
            end else if (rand_en && $urandom_range(0, 3) == 0) begin
                cur[0] = mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15), $urandom);
                cur_vld[0] = 1'b1;
            end
        end
        if (!cur_vld[1]) begin
            if (qb.size() > 0) begin
                cur[1] = qb.pop_front(); cur_vld[1] = 1'b1;
            end else if (rand_en && $urandom_range(0, 3) == 0) begin
                cur[1] = mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15), $urandom);
                cur_vld[1] = 1'b1;
            end
        end
        drive();
    endtask

    task automatic step();
        int    w;
        op_t   op;
        bit    bad;
        bit    g [2];
        bit    rv;
        string nm;
        g[0] = 1'b0;
        g[1] = 1'b0;
        @(posedge clk);
        t++;
        if (t >= free_at && (cur_vld[0] || cur_vld[1])) begin
            if (cur_vld[0] && cur_vld[1]) w = last_b ? 0 : 1;
            else                          w = cur_vld[1] ? 1 : 0;
            last_b   = (w == 1);
            free_at  = t + 3;
            gnt_t[w] = t;
            g[w]     = 1'b1;
            op       = cur[w];
            exp_r1[w] = ref_regs[op.s1];
            exp_r2[w] = ref_regs[op.s2];
            bad = op.we && (op.s1 == 0 || op.s1 >= 14);
            exp_err[w] = bad;
            if (op.we && !bad) begin
                ref_regs[op.s1] = op.wd;
                wen_t = t;
            end
        end
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            nm = (r == 1) ? "b_" : "a_";
            rv = (gnt_t[r] == t - 1);
            chk({nm, "gnt"},    32'(gnt_v[r]), 32'(g[r]));
            chk({nm, "rvalid"}, 32'(rv_v[r]),  32'(rv));
            chk({nm, "rdata1"}, 32'(rd1_v[r]), rv ? 32'(exp_r1[r]) : 32'd0);
            chk({nm, "rdata2"}, 32'(rd2_v[r]), rv ? 32'(exp_r2[r]) : 32'd0);
            chk({nm, "err"},    32'(err_v[r]), 32'(rv && exp_err[r]));
            if (gnt_v[r]) cnt_gnt[r]++;
            if (g[r]) cur_vld[r] = 1'b0;
        end
        chk("rf_write_en", 32'(rf_write_en), 32'(wen_t == t));
        refill();
    endtask

    task automatic run_phase(int max_cyc);
        int n;
        n = 0;
        refill();
        while ((qa.size() > 0 || qb.size() > 0 || cur_vld[0] || cur_vld[1] || t < free_at) && n < max_cyc) begin
            step();
            n++;
        end
    endtask

    initial begin
        rst = 1'b1;
        pl  = 1'b1;
        cur[0] = mk(0, 0, 0, 0); cur[1] = mk(0, 0, 0, 0);
        cur_vld[0] = 1'b0; cur_vld[1] = 1'b0;
        rand_en = 1'b0;
        drive();
        for (int i = 0; i < 16; i++) ref_regs[i] = init_val(i);
        repeat (2) @(negedge clk);
        pl = 1'b0;

        chk("rst_a_gnt", 32'(a_gnt), 0);      chk("rst_b_gnt", 32'(b_gnt), 0);
        chk("rst_a_rvalid", 32'(a_rvalid), 0); chk("rst_b_rvalid", 32'(b_rvalid), 0);
        chk("rst_a_rdata1", 32'(a_rdata1), 0); chk("rst_b_err", 32'(b_err), 0);
        chk("rst_rf_sel1", 32'(rf_sel1), 0);   chk("rst_rf_sel2", 32'(rf_sel2), 0);
        chk("rst_rf_in", 32'(rf_in), 0);       chk("rst_rf_write_en", 32'(rf_write_en), 0);
        rst = 1'b0;

        // Reset during ISSUE of a B write: the write and the response must both vanish.
        b_req = 1'b1; b_we = 1'b1; b_sel1 = 4'd7; b_sel2 = 4'd7; b_wdata = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        chk("t5_b_gnt", 32'(b_gnt), 1);
        chk("t5_wen", 32'(rf_write_en), 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_wen_rst", 32'(rf_write_en), 0);
        chk("t5_b_gnt_rst", 32'(b_gnt), 0);
        b_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t5_b_rvalid", 32'(b_rvalid), 0);
        end
        chk("t5_r7", 32'(mem[7]), 32'h0707);

        t = 0; free_at = 0; wen_t = -10; last_b = 1'b1;
        gnt_t[0] = -10; gnt_t[1] = -10;

        // Simultaneous requests right after reset: A first.
        qa.push_back(mk(0, 3, 5, 0));
        qb.push_back(mk(0, 7, 2, 0));
        run_phase(50);

        // A alone: read, write r2 then read back, then rejected writes to r0/r14/r15.
        qa.push_back(mk(0, 3, 5, 0));
        qa.push_back(mk(1, 2, 3, 16'hA5A5));
        qa.push_back(mk(0, 2, 2, 0));
        qa.push_back(mk(1, 0, 1, 16'hDEAD));
        qa.push_back(mk(1, 14, 15, 16'hDEAD));
        qa.push_back(mk(1, 15, 14, 16'hDEAD));
        run_phase(100);

        // B alone, back to back.
        cnt_gnt[0] = 0; cnt_gnt[1] = 0;
        for (int i = 0; i < 4; i++) qb.push_back(mk(i[0], 8 + i, i, 16'h1000 + i));
        run_phase(100);
        chk("t6_b_gnt_cnt", 32'(cnt_gnt[1]), 4);
        chk("t6_a_gnt_cnt", 32'(cnt_gnt[0]), 0);

        // Both held: strict alternation starting with A since B was granted last.
        for (int i = 0; i < 3; i++) begin
            qa.push_back(mk(1, 9, 10, 16'h2000 + i));
            qb.push_back(mk(0, 9, 11, 0));
        end
        run_phase(100);

        rand_en = 1'b1;
        repeat (900) step();
        rand_en = 1'b0;
        run_phase(100);

        for (int i = 0; i < 16; i++) chk("final_mem", 32'(mem[i]), 32'(ref_regs[i]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
